pipelined_multimode_barrel_shifter: RTL

//  Parametrised, pipelined barrel shifter with valid/ready streaming handshake.

---
 rtl/pipelined_multimode_barrel_shifter_if.sv | 44 ++++
 rtl/pipelined_multimode_barrel_shifter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pipelined_multimode_barrel_shifter_if.sv
// Streaming handshake bundle for the multimode barrel shifter.
// The producer/consumer side uses master; the shifter uses slave.
interface pipelined_multimode_barrel_shifter_if #(
    parameter int WIDTH = 8
);
    localparam int AMT_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic             in_dir;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;

    modport master (
        output in_valid,
        output in_data,
        output in_amt,
        output in_dir,
        output in_mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_zero
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_amt,
        input  in_dir,
        input  in_mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_zero
    );
endinterface

// File: rtl/pipelined_multimode_barrel_shifter.sv
// Pipelined rotate/logical/arithmetic barrel shifter, left or right,
// with a global-stall valid/ready stream on both sides.
module pipelined_multimode_barrel_shifter #(
    parameter int WIDTH = 8,
    parameter int PIPE  = 0
) (
    input logic clk,
    input logic rst_n,
    pipelined_multimode_barrel_shifter_if.slave sh
);
    localparam int AMT_W = $clog2(WIDTH);

    typedef logic [WIDTH-1:0] data_t;
    typedef logic [AMT_W-1:0] amt_t;

    function automatic data_t bit_rev(input data_t d);
        data_t r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = d[WIDTH-1-i];
        end
        return r;
    endfunction

    // Right shift by sh; vacated top bits wrap (rotate) or take fill.
    function automatic data_t shr_fill(
        input data_t d,
        input int    sh,
        input logic  rot,
        input logic  fill
    );
        data_t r;
        for (int i = 0; i < WIDTH; i++) begin
            if (i + sh < WIDTH) begin
                r[i] = d[i+sh];
            end else if (rot) begin
                r[i] = d[i+sh-WIDTH];
            end else begin
                r[i] = fill;
            end
        end
        return r;
    endfunction

    logic  stall;
    logic  out_vld_q;
    data_t out_data_q;
    logic  out_vld_d;
    data_t out_data_d;

    data_t fe_data;
    logic  fe_rot;
    logic  fe_sgn;

    assign stall       = out_vld_q & ~sh.out_ready;
    assign sh.in_ready = ~stall;

    // Left ops run through the right-shift core on reversed data.
    assign fe_data = sh.in_dir ? sh.in_data : bit_rev(sh.in_data);
    assign fe_rot  = (sh.in_mode == 2'b00) | (sh.in_mode == 2'b11);
    assign fe_sgn  = sh.in_dir & (sh.in_mode == 2'b10)
                   & sh.in_data[WIDTH-1];

    if (PIPE != 0) begin : g_pipe
        localparam int NP = AMT_W - 1;

        logic  vld_q [NP];
        data_t data_q[NP];
        amt_t  amt_q [NP];
        logic  dir_q [NP];
        logic  rot_q [NP];
        logic  sgn_q [NP];
        data_t nxt_d [NP];
        data_t fin;

        always_comb begin
            nxt_d[0] = sh.in_amt[0]
                     ? shr_fill(fe_data, 1, fe_rot, fe_sgn)
                     : fe_data;
            for (int k = 1; k < NP; k++) begin
                nxt_d[k] = amt_q[k-1][k]
                         ? shr_fill(data_q[k-1], 1 << k,
                                    rot_q[k-1], sgn_q[k-1])
                         : data_q[k-1];
            end
            fin = amt_q[NP-1][AMT_W-1]
                ? shr_fill(data_q[NP-1], 1 << (AMT_W - 1),
                           rot_q[NP-1], sgn_q[NP-1])
                : data_q[NP-1];
            out_vld_d  = vld_q[NP-1];
            out_data_d = dir_q[NP-1] ? fin : bit_rev(fin);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < NP; k++) begin
                    vld_q[k]  <= 1'b0;
                    data_q[k] <= '0;
                    amt_q[k]  <= '0;
                    dir_q[k]  <= 1'b0;
                    rot_q[k]  <= 1'b0;
                    sgn_q[k]  <= 1'b0;
                end
            end else if (!stall) begin
                vld_q[0]  <= sh.in_valid;
                data_q[0] <= nxt_d[0];
                amt_q[0]  <= sh.in_amt;
                dir_q[0]  <= sh.in_dir;
                rot_q[0]  <= fe_rot;
                sgn_q[0]  <= fe_sgn;
                for (int k = 1; k < NP; k++) begin
                    vld_q[k]  <= vld_q[k-1];
                    data_q[k] <= nxt_d[k];
                    amt_q[k]  <= amt_q[k-1];
                    dir_q[k]  <= dir_q[k-1];
                    rot_q[k]  <= rot_q[k-1];
                    sgn_q[k]  <= sgn_q[k-1];
                end
            end
        end
    end else begin : g_comb
        data_t d;

        always_comb begin
            d = fe_data;
            for (int k = 0; k < AMT_W; k++) begin
                if (sh.in_amt[k]) begin
                    d = shr_fill(d, 1 << k, fe_rot, fe_sgn);
                end
            end
            out_vld_d  = sh.in_valid;
            out_data_d = sh.in_dir ? d : bit_rev(d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else if (!stall) begin
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
        end
    end

    assign sh.out_valid = out_vld_q;
    assign sh.out_data  = out_data_q;
    assign sh.out_zero  = (out_data_q == '0);
endmodule
